// File: rtl/ccd_line_avg.sv
// ccd_line_avg: averages 2^k consecutive sensor lines pixel-by-pixel using a
// per-column accumulator RAM, and emits one rounded averaged line per group.
// Optional feature macro: CCD_LINE_AVG_DARK_EN adds a dark_level port whose
// value is subtracted (clamped at zero) from every averaged pixel.
module ccd_line_avg #(
    parameter int DATA_WIDTH   = 8,
    parameter int COLS         = 2048,
    parameter int AVG_LOG2_MAX = 3
) (
    input  logic                  pxl_clk,
    input  logic                  rst_n,
    input  logic [1:0]            avg_log2,
`ifdef CCD_LINE_AVG_DARK_EN
    input  logic [DATA_WIDTH-1:0] dark_level,
`endif
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    input  logic                  s_axis_tuser,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic                  m_axis_tuser,
    output logic                  line_err
);

    localparam int ACC_W = DATA_WIDTH + AVG_LOG2_MAX;
    localparam int SUM_W = ACC_W + 1;
    localparam int KW    = (AVG_LOG2_MAX > 0) ? $clog2(AVG_LOG2_MAX + 1) : 1;
    localparam int GW    = (AVG_LOG2_MAX > 0) ? AVG_LOG2_MAX : 1;
    localparam int CW    = (COLS > 1) ? $clog2(COLS) : 1;
    localparam logic [CW-1:0] LAST_COL = CW'(COLS - 1);

    // IDLE waits for a frame start, ACTIVE processes pixels, DISCARD drops
    // the tail of an over-long line until its tlast arrives.
    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        DISCARD
    } state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         col_cnt_q, col_cnt_d;
    logic [GW-1:0]         grp_cnt_q, grp_cnt_d;
    logic [KW-1:0]         k_lat_q, k_lat_d;
    logic                  line_err_q, line_err_d;
    logic                  first_emit_q, first_emit_d;
    logic                  m_valid_q, m_valid_d;
    logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
    logic                  m_last_q, m_last_d;
    logic                  m_user_q, m_user_d;
`ifdef CCD_LINE_AVG_DARK_EN
    logic [DATA_WIDTH-1:0] dark_lat_q, dark_lat_d;
    logic [DATA_WIDTH-1:0] dark_eff;
`endif

    logic [ACC_W-1:0]      acc_mem [COLS];
    logic [ACC_W-1:0]      acc_rd_q;

    logic                  accept;
    logic [KW-1:0]         k_new;
    logic [KW-1:0]         k_eff;
    logic [GW-1:0]         grp_eff;
    logic [GW-1:0]         grp_max;
    logic [CW-1:0]         col_eff;
    logic                  flag_eff;
    logic                  do_proc;
    logic                  is_emit;
    logic [ACC_W-1:0]      acc_term;
    logic [SUM_W-1:0]      round_val;
    logic [SUM_W-1:0]      sum_full;
    logic [SUM_W-1:0]      avg_full;
    logic [DATA_WIDTH-1:0] pix_avg;
    logic [DATA_WIDTH-1:0] pix_out;
    logic                  wr_en;
    logic [CW-1:0]         wr_addr;
    logic [ACC_W-1:0]      wr_data;
    logic [CW-1:0]         rd_addr;

    assign s_axis_tready = !m_valid_q || m_axis_tready;
    assign accept        = s_axis_tvalid && s_axis_tready;
    assign k_new         = (int'(avg_log2) > AVG_LOG2_MAX) ? KW'(AVG_LOG2_MAX) : KW'(avg_log2);

    assign m_axis_tdata  = m_data_q;
    assign m_axis_tvalid = m_valid_q;
    assign m_axis_tlast  = m_last_q;
    assign m_axis_tuser  = m_user_q;
    assign line_err      = line_err_q;

    // Beat classification, accumulate/emit datapath and next-state logic.
    always_comb begin
        state_d      = state_q;
        col_cnt_d    = col_cnt_q;
        grp_cnt_d    = grp_cnt_q;
        k_lat_d      = k_lat_q;
        line_err_d   = line_err_q;
        first_emit_d = first_emit_q;
        m_valid_d    = m_valid_q && !m_axis_tready;
        m_data_d     = m_data_q;
        m_last_d     = m_last_q;
        m_user_d     = m_user_q;
`ifdef CCD_LINE_AVG_DARK_EN
        dark_lat_d   = dark_lat_q;
        dark_eff     = dark_lat_q;
`endif
        k_eff        = k_lat_q;
        grp_eff      = grp_cnt_q;
        col_eff      = col_cnt_q;
        flag_eff     = first_emit_q;
        do_proc      = 1'b0;
        wr_en        = 1'b0;

        if (accept) begin
            if (s_axis_tuser) begin
                // A frame start in the middle of a line closes that line as short.
                line_err_d   = (state_q == DISCARD) ||
                               ((state_q == ACTIVE) && (col_cnt_q != '0));
                k_lat_d      = k_new;
                k_eff        = k_new;
                grp_eff      = '0;
                col_eff      = '0;
                flag_eff     = 1'b1;
                first_emit_d = 1'b1;
`ifdef CCD_LINE_AVG_DARK_EN
                dark_lat_d   = dark_level;
                dark_eff     = dark_level;
`endif
                do_proc      = 1'b1;
            end else if (state_q == ACTIVE) begin
                do_proc = 1'b1;
            end else if ((state_q == DISCARD) && s_axis_tlast) begin
                state_d   = ACTIVE;
                col_cnt_d = '0;
                grp_cnt_d = '0;
            end
        end

        grp_max   = GW'((32'd1 << k_eff) - 32'd1);
        round_val = (k_eff == '0) ? '0 : SUM_W'(32'd1 << (k_eff - KW'(1)));
        acc_term  = (grp_eff == '0) ? '0 : acc_rd_q;
        sum_full  = SUM_W'(acc_term) + SUM_W'(s_axis_tdata) + round_val;
        avg_full  = sum_full >> k_eff;
        pix_avg   = (|avg_full[SUM_W-1:DATA_WIDTH]) ? '1 : avg_full[DATA_WIDTH-1:0];
`ifdef CCD_LINE_AVG_DARK_EN
        pix_out   = (pix_avg > dark_eff) ? (pix_avg - dark_eff) : '0;
`else
        pix_out   = pix_avg;
`endif
        is_emit   = (grp_eff == grp_max);
        wr_addr   = col_eff;
        wr_data   = acc_term + ACC_W'(s_axis_tdata);

        if (do_proc) begin
            state_d = ACTIVE;
            if (is_emit) begin
                m_valid_d = 1'b1;
                m_data_d  = pix_out;
                m_last_d  = (col_eff == LAST_COL) || s_axis_tlast;
                m_user_d  = flag_eff && (col_eff == '0);
                if (col_eff == '0) begin
                    first_emit_d = 1'b0;
                end
            end else begin
                wr_en = 1'b1;
            end

            if (s_axis_tlast) begin
                col_cnt_d = '0;
                if (col_eff == LAST_COL) begin
                    grp_cnt_d = (grp_eff == grp_max) ? '0 : (grp_eff + GW'(1));
                end else begin
                    line_err_d = 1'b1;
                    grp_cnt_d  = '0;
                end
            end else if (col_eff == LAST_COL) begin
                line_err_d = 1'b1;
                state_d    = DISCARD;
                col_cnt_d  = col_eff;
                grp_cnt_d  = grp_eff;
            end else begin
                col_cnt_d = col_eff + CW'(1);
                grp_cnt_d = grp_eff;
            end
        end

        rd_addr = accept ? col_cnt_d : col_cnt_q;
    end

    // Control and output registers.
    always_ff @(posedge pxl_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            col_cnt_q    <= '0;
            grp_cnt_q    <= '0;
            k_lat_q      <= '0;
            line_err_q   <= 1'b0;
            first_emit_q <= 1'b0;
            m_valid_q    <= 1'b0;
            m_data_q     <= '0;
            m_last_q     <= 1'b0;
            m_user_q     <= 1'b0;
`ifdef CCD_LINE_AVG_DARK_EN
            dark_lat_q   <= '0;
`endif
        end else begin
            state_q      <= state_d;
            col_cnt_q    <= col_cnt_d;
            grp_cnt_q    <= grp_cnt_d;
            k_lat_q      <= k_lat_d;
            line_err_q   <= line_err_d;
            first_emit_q <= first_emit_d;
            m_valid_q    <= m_valid_d;
            m_data_q     <= m_data_d;
            m_last_q     <= m_last_d;
            m_user_q     <= m_user_d;
`ifdef CCD_LINE_AVG_DARK_EN
            dark_lat_q   <= dark_lat_d;
`endif
        end
    end

    // Accumulator RAM: the read runs one column ahead so acc[col] is ready when that pixel is accepted.
    always_ff @(posedge pxl_clk) begin
        if (wr_en) begin
            acc_mem[wr_addr] <= wr_data;
        end
        acc_rd_q <= acc_mem[rd_addr];
    end

endmodule

// File: tb/tb_ccd_line_avg.sv
// tb_ccd_line_avg: randomized scoreboard bench for ccd_line_avg with a line-level reference model.
module tb_ccd_line_avg;

    localparam int DW   = 8;
    localparam int COLS = 2048;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
        logic          user;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [1:0]    avg_log2 = 2'd0;
    logic [DW-1:0] dark_level = '0;
    logic [DW-1:0] s_tdata = '0;
    logic          s_tvalid = 1'b0;
    logic          s_tready;
    logic          s_tlast = 1'b0;
    logic          s_tuser = 1'b0;
    logic [DW-1:0] m_tdata;
    logic          m_tvalid;
    logic          m_tready = 1'b1;
    logic          m_tlast;
    logic          m_tuser;
    logic          line_err;

    int            errors = 0;
    int            checks = 0;
    int            out_idx = 0;
    int            ready_mode = 0;
    bit            gap_mode = 1'b0;

    beat_t         exp_q[$];
    logic [DW-1:0] pix [COLS + 64];
    int            m_sum [COLS];
    int            m_k = 0;
    int            m_count = 0;
    int            m_dark = 0;
    bit            m_idle = 1'b1;
    bit            m_first = 1'b0;
    bit            m_err = 1'b0;
    bit            m_mid = 1'b0;

    ccd_line_avg #(
        .DATA_WIDTH  (DW),
        .COLS        (COLS),
        .AVG_LOG2_MAX(3)
    ) dut (
        .pxl_clk      (clk),
        .rst_n        (rst_n),
        .avg_log2     (avg_log2),
`ifdef CCD_LINE_AVG_DARK_EN
        .dark_level   (dark_level),
`endif
        .s_axis_tdata (s_tdata),
        .s_axis_tvalid(s_tvalid),
        .s_axis_tready(s_tready),
        .s_axis_tlast (s_tlast),
        .s_axis_tuser (s_tuser),
        .m_axis_tdata (m_tdata),
        .m_axis_tvalid(m_tvalid),
        .m_axis_tready(m_tready),
        .m_axis_tlast (m_tlast),
        .m_axis_tuser (m_tuser),
        .line_err     (line_err)
    );

    always #5 clk = ~clk;

    // Reference model: one call per driven line, using the current pix[] contents.
    function automatic void modelLine(input int len, input bit tuser, input bit tlast_end,
                                      input int k, input int dark);
        int    group_len;
        int    ncols;
        bit    emit;
        int    s;
        int    avg;
        beat_t b;
        if (tuser) begin
            m_err   = m_mid;
            m_mid   = 1'b0;
            m_idle  = 1'b0;
            m_k     = (k > 3) ? 3 : k;
            m_dark  = dark;
            m_count = 0;
            m_first = 1'b1;
        end
        if (m_idle) return;
        group_len = 1 << m_k;
        emit      = (m_count == group_len - 1);
        ncols     = (len < COLS) ? len : COLS;
        for (int c = 0; c < ncols; c++) begin
            s = ((m_count == 0) ? 0 : m_sum[c]) + int'(pix[c]);
            if (emit) begin
                avg = (s + group_len / 2) / group_len;
`ifdef CCD_LINE_AVG_DARK_EN
                avg = (avg > m_dark) ? avg - m_dark : 0;
`endif
                b.data = DW'(avg);
                b.last = (c == COLS - 1) || ((c == len - 1) && tlast_end);
                b.user = m_first && (c == 0);
                if (c == 0) m_first = 1'b0;
                exp_q.push_back(b);
            end else begin
                m_sum[c] = s;
            end
        end
        if ((len == COLS) && tlast_end) begin
            m_count = emit ? 0 : m_count + 1;
        end else if ((len < COLS) && !tlast_end) begin
            m_mid = 1'b1;
        end else begin
            m_err   = 1'b1;
            m_count = 0;
        end
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input int len, input bit tuser, input bit tlast_end,
                                 input int k, input int dark);
        bit ok;
        modelLine(len, tuser, tlast_end, k, dark);
        for (int c = 0; c < len; c++) begin
            if (gap_mode && ($urandom_range(3) == 0)) begin
                s_tvalid = 1'b0;
                @(posedge clk);
                #1;
            end
            s_tdata = pix[c];
            s_tuser = tuser && (c == 0);
            s_tlast = tlast_end && (c == len - 1);
            if (tuser && (c == 0)) begin
                avg_log2   = 2'(k);
                dark_level = DW'(dark);
            end else begin
                avg_log2   = 2'($urandom_range(3));
                dark_level = DW'($urandom);
            end
            s_tvalid = 1'b1;
            ok = 1'b0;
            for (int t = 0; (t < 1000) && !ok; t++) begin
                @(negedge clk);
                ok = s_tready;
                @(posedge clk);
                #1;
            end
            if (!ok) begin
                checks++;
                errors++;
                $display("[TB] FAIL input_handshake col=%0d s_axis_tready stuck at 0, required 1", c);
            end
        end
        s_tvalid = 1'b0;
        s_tuser  = 1'b0;
        s_tlast  = 1'b0;
        checkOutput("line_err", int'(line_err), int'(m_err));
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (((exp_q.size() != 0) || m_tvalid) && (t < 5000)) begin
            @(posedge clk);
            #1;
            t++;
        end
        checkOutput("pending_outputs", exp_q.size(), 0);
    endtask

    task automatic fillRandom();
        for (int c = 0; c < COLS + 64; c++) pix[c] = DW'($urandom);
    endtask

    task automatic fillConst(input int v);
        for (int c = 0; c < COLS + 64; c++) pix[c] = DW'(v);
    endtask

    // Downstream ready pattern: steady, toggling every cycle, or random.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                1:       m_tready = ~m_tready;
                2:       m_tready = 1'($urandom_range(1));
                default: m_tready = 1'b1;
            endcase
        end
    end

    // Monitor: checks backpressure and pops the scoreboard on every output handshake.
    always @(negedge clk) begin
        beat_t e;
        if (rst_n) begin
            checks++;
            if (s_tready !== (!m_tvalid || m_tready)) begin
                errors++;
                $display("[TB] FAIL s_tready actual=%0b expected=%0b", s_tready, (!m_tvalid || m_tready));
            end
            if (m_tvalid && m_tready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL unexpected_output idx=%0d data=%0d last=%0b user=%0b, required none",
                             out_idx, m_tdata, m_tlast, m_tuser);
                end else begin
                    e = exp_q.pop_front();
                    if ({m_tdata, m_tlast, m_tuser} !== {e.data, e.last, e.user}) begin
                        errors++;
                        $display("[TB] FAIL out_beat idx=%0d data=%0d last=%0b user=%0b, required data=%0d last=%0b user=%0b",
                                 out_idx, m_tdata, m_tlast, m_tuser, e.data, e.last, e.user);
                    end
                end
                out_idx++;
            end
        end
    end

    initial begin
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("reset_m_tvalid", int'(m_tvalid), 0);
        checkOutput("reset_m_tdata", int'(m_tdata), 0);
        checkOutput("reset_m_tlast", int'(m_tlast), 0);
        checkOutput("reset_m_tuser", int'(m_tuser), 0);
        checkOutput("reset_line_err", int'(line_err), 0);
        checkOutput("reset_s_tready", int'(s_tready), 1);
        @(posedge clk);
        #1;

        $display("[TB] beats before any frame start are dropped");
        fillRandom();
        applyStimulus(5, 1'b0, 1'b0, 0, 0);

        $display("[TB] k=0 pass-through, 3 lines");
        for (int c = 0; c < COLS + 64; c++) pix[c] = DW'(c % 256);
        applyStimulus(COLS, 1'b1, 1'b1, 0, 0);
        applyStimulus(COLS, 1'b0, 1'b1, 0, 0);
        applyStimulus(COLS, 1'b0, 1'b1, 0, 0);
        drain();

        $display("[TB] k=2 constant lines 10..13");
        fillConst(10);
        applyStimulus(COLS, 1'b1, 1'b1, 2, 0);
        checkOutput("no_output_during_group", exp_q.size() + int'(m_tvalid), 0);
        for (int l = 1; l < 4; l++) begin
            fillConst(10 + l);
            applyStimulus(COLS, 1'b0, 1'b1, 2, 0);
        end
        drain();

        $display("[TB] k=3 all 255, then k=1 with 0 and 1");
        fillConst(255);
        applyStimulus(COLS, 1'b1, 1'b1, 3, 0);
        for (int l = 1; l < 8; l++) applyStimulus(COLS, 1'b0, 1'b1, 3, 0);
        drain();
        fillConst(0);
        applyStimulus(COLS, 1'b1, 1'b1, 1, 0);
        fillConst(1);
        applyStimulus(COLS, 1'b0, 1'b1, 1, 0);
        drain();

        $display("[TB] k=1 random pixels with toggling downstream ready");
        ready_mode = 1;
        fillRandom();
        applyStimulus(COLS, 1'b1, 1'b1, 1, 0);
        fillRandom();
        applyStimulus(COLS, 1'b0, 1'b1, 1, 0);
        drain();
        ready_mode = 0;

        $display("[TB] mid-line frame start, then frame start with tlast on one beat");
        fillRandom();
        applyStimulus(30, 1'b1, 1'b0, 1, 0);
        applyStimulus(1, 1'b1, 1'b1, 0, 0);
        drain();

        $display("[TB] short line of 100 beats, then recovery");
        fillRandom();
        applyStimulus(100, 1'b1, 1'b1, 1, 0);
        fillRandom();
        applyStimulus(COLS, 1'b0, 1'b1, 1, 0);
        fillRandom();
        applyStimulus(COLS, 1'b0, 1'b1, 1, 0);
        drain();
        ready_mode = 2;
        fillRandom();
        applyStimulus(COLS, 1'b1, 1'b1, 0, 0);
        drain();

        $display("[TB] long line, then recovery with input gaps and random ready");
        gap_mode = 1'b1;
        fillRandom();
        applyStimulus(COLS + 12, 1'b1, 1'b1, 1, 0);
        fillRandom();
        applyStimulus(COLS, 1'b0, 1'b1, 1, 0);
        fillRandom();
        applyStimulus(COLS, 1'b0, 1'b1, 1, 0);
        drain();

        $display("[TB] reset in the middle of a line");
        fillRandom();
        applyStimulus(50, 1'b1, 1'b0, 1, 0);
        drain();
        rst_n = 1'b0;
        m_idle = 1'b1;
        m_err  = 1'b0;
        m_mid  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("midreset_m_tvalid", int'(m_tvalid), 0);
        checkOutput("midreset_line_err", int'(line_err), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] k=0 frame after reset with dark level 20");
        fillRandom();
        pix[0] = DW'(15);
        pix[1] = DW'(50);
        applyStimulus(COLS, 1'b1, 1'b1, 0, 20);
        drain();
        gap_mode   = 1'b0;
        ready_mode = 0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ccd_line_avg.md
Name: ccd_line_avg

Overview:
Downstream consumer of the CCD front end's 8-bit AXI-Stream output, i.e. the pixel-clock stream carrying tdata/tlast/tuser from the line-sensor top.
Averages 2^k consecutive sensor lines pixel-by-pixel to reduce temporal noise, using a per-column accumulator RAM.
Emits one averaged line per group of 2^k input lines, as an AXI-Stream on the same clock.
k = 0 gives pass-through with one cycle of latency.

Parameters:
DATA_WIDTH, 8, pixel width on both streams
COLS, 2048, effective pixels per line
AVG_LOG2_MAX, 3, maximum k; accumulator width ACC_W = DATA_WIDTH + AVG_LOG2_MAX

Ports:
pxl_clk  in  1  pixel clock, all logic synchronous to it
rst_n  in  1  asynchronous active-low reset
avg_log2  in  2  k, number of lines averaged = 2^k; values above AVG_LOG2_MAX clamp to AVG_LOG2_MAX
s_axis_tdata  in  DATA_WIDTH  input pixel
s_axis_tvalid  in  1  input beat valid
s_axis_tready  out  1  input ready
s_axis_tlast  in  1  last pixel of line
s_axis_tuser  in  1  first pixel of frame
m_axis_tdata  out  DATA_WIDTH  averaged pixel
m_axis_tvalid  out  1  output valid
m_axis_tready  in  1  downstream ready
m_axis_tlast  out  1  last pixel of averaged line
m_axis_tuser  out  1  first pixel of first averaged line of frame
line_err  out  1  sticky line-length error; cleared by the next s_axis_tuser beat or by reset

Behaviour:
- Reset values: m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0, m_axis_tuser=0, line_err=0. Internal col_cnt=0, grp_cnt=0, state=IDLE.
- Accept: a beat is accepted when s_axis_tvalid & s_axis_tready.
- Ready: s_axis_tready = !m_axis_tvalid | m_axis_tready, giving a single output register. It is 1 in all non-emitting cases.
- k latch: k_lat is latched from avg_log2 on each accepted tuser beat. It is held for the whole frame.
- States:
  - IDLE: wait for a tuser beat. Beats without tuser are accepted and dropped. On a tuser beat: k_lat is latched, grp_cnt=0, and the beat is processed as column 0.
  - FIRST (grp_cnt==0, k_lat>0): write acc[col] = pixel.
  - MID (0<grp_cnt<2^k-1): write acc[col] = acc[col] + pixel.
  - EMIT (grp_cnt==2^k-1, or k_lat==0): output (acc[col] + pixel + round) >> k_lat, where round = 2^(k_lat-1) if k_lat>0, else 0. No RAM write in this state. The result never exceeds 2^DATA_WIDTH-1.
- Latency: the output beat is registered and is valid 1 cycle after the accepting edge.
- m_axis_tlast=1 on output col COLS-1.
- m_axis_tuser=1 on col 0 of the first EMIT line after tuser.
- RAM: COLS x ACC_W, synchronous read.
  - Read address = col_cnt+1 on accept, otherwise col_cnt, so acc[col] is available at the accept cycle.
  - At the line wrap, the read address is 0.
- Line end: the accepted tlast beat at col_cnt==COLS-1 sets col_cnt=0 and advances grp_cnt. After the last line of a group, grp_cnt wraps to 0.
- Short line: tlast at col_cnt<COLS-1 sets line_err=1, col_cnt=0, grp_cnt=0, and the partial group is discarded. If in EMIT, the output already emitted stands; m_axis_tlast is forced 1 on that beat.
- Long line: beats with col_cnt==COLS-1 without tlast set line_err=1. Further beats are accepted and dropped until tlast; col_cnt saturates.
- Mid-line tuser: treated as a short line of the old frame (line_err=1), then as col 0 of the new frame.
- Simultaneous tlast & tuser on one beat: processed as a tuser beat at col 0, with the short-line error.
- Reset mid-line: everything returns to IDLE. Accumulator contents are don't-care because FIRST overwrites them.
- Changes to avg_log2 mid-frame are ignored until the next tuser.

Optional Feature:
Macro CCD_LINE_AVG_DARK_EN.
- Defined: adds input port dark_level (DATA_WIDTH), sampled with k_lat on tuser. The output becomes max(avg - dark_level, 0), still 1-cycle latency.
- Undefined: no port, and the output is the plain rounded average.

Test Plan:
- k=0, frame of 3 lines, pixel[i]=i mod 256, m_axis_tready=1 -> output identical to input, delayed 1 cycle; tuser on beat 0; tlast every 2048th beat; line_err=0.
- k=2, lines of constant 10, 11, 12, 13 -> one output line, all pixels (46+2)>>2 = 12; no output during the first 3 lines.
- k=3, 8 lines all 255 -> output all 255 (no overflow); k=1 with lines 0 and 1 -> output 1 (rounding up).
- k=1, m_axis_tready toggling 1-0-1 every cycle during EMIT -> s_axis_tready mirrors the stall; no beat lost or duplicated; 2048 outputs with correct values.
- Line of 100 beats ending with tlast -> line_err=1, grp restarts; the next 2 full lines (k=1) produce a correct averaged line; a new tuser clears line_err.
- CCD_LINE_AVG_DARK_EN defined, dark_level=20, k=0, pixels 15 and 50 -> outputs 0 and 30.
